// File: rtl/pipe_front_ctrl_if.sv
// Bundle of the hazard-control, redirect, instruction-fetch and pipeline
// register signals exchanged between pipe_front_ctrl and its surroundings.
// The master side is the rest of the CPU (hazard unit, EXE stage, imem).
// The slave side is the front-end register block itself.
interface pipe_front_ctrl_if #(
  parameter int unsigned CNT_W = 16
);

  // Hazard-unit controls and branch redirect
  logic             pc_write;
  logic             if_id_write;
  logic             id_exe_flush;
  logic             branch_taken;
  logic [31:0]      branch_target;

  // Combinational instruction-memory read data at address pc
  logic [31:0]      imem_instr;

  // Registered front-end state
  logic [31:0]      pc;
  logic [31:0]      if_id_instr;
  logic [31:0]      if_id_pc4;
  logic             if_id_valid;
  logic [31:0]      id_exe_instr;
  logic [31:0]      id_exe_pc4;
  logic             id_exe_valid;

  // Event counters and sticky control-consistency flag
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             ctrl_err;

  modport master (
    output pc_write, if_id_write, id_exe_flush, branch_taken, branch_target,
    output imem_instr,
    input  pc, if_id_instr, if_id_pc4, if_id_valid,
    input  id_exe_instr, id_exe_pc4, id_exe_valid,
    input  stall_cnt, flush_cnt, ctrl_err
  );

  modport slave (
    input  pc_write, if_id_write, id_exe_flush, branch_taken, branch_target,
    input  imem_instr,
    output pc, if_id_instr, if_id_pc4, if_id_valid,
    output id_exe_instr, id_exe_pc4, id_exe_valid,
    output stall_cnt, flush_cnt, ctrl_err
  );

endinterface

// File: rtl/pipe_front_ctrl.sv
// Front-end pipeline register block of the 5-stage CPU: holds the PC, the
// IF/ID register and the ID/EXE instruction register, and applies the
// load-use stall/bubble controls and the branch redirect/flush. A taken
// branch always wins over a simultaneous stall, because the stalled load is
// younger than the branch and is discarded anyway.
module pipe_front_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input logic              clk,
  input logic              rst,
  pipe_front_ctrl_if.slave bus
);

  // One pipeline stage slot: instruction word, its pc+4 and a valid flag.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } stage_t;

  // Content of a slot that holds a bubble or a flushed instruction.
  localparam stage_t BUBBLE = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [31:0]      pc_q,        pc_d;
  stage_t           if_id_q,     if_id_d;
  stage_t           id_exe_q,    id_exe_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             ctrl_err_q,  ctrl_err_d;

  logic [31:0]      pc_plus4;

  // Sequential fetch address; wraps modulo 2^32.
  assign pc_plus4 = pc_q + 32'd4;

  // Next PC: redirect beats advance, advance beats hold.
  always_comb begin
    // NOTE: each always_comb assigns its outputs a default first, so no path leaves them unassigned and no latch is inferred.
    pc_d = pc_q;
    if (bus.branch_taken) begin
      pc_d = bus.branch_target;
    end else if (bus.pc_write) begin
      pc_d = pc_plus4;
    end
  end

  // Next IF/ID slot: flush on redirect, load new fetch, or hold.
  always_comb begin
    if_id_d = if_id_q;
    if (bus.branch_taken) begin
      if_id_d = BUBBLE;
    end else if (bus.if_id_write) begin
      if_id_d = '{instr: bus.imem_instr, pc4: pc_plus4, valid: 1'b1};
    end
  end

  // Next ID/EXE slot: bubble on redirect or load-use flush, else pass IF/ID.
  always_comb begin
    id_exe_d = if_id_q;
    if (bus.branch_taken || bus.id_exe_flush) begin
      id_exe_d = BUBBLE;
    end
  end

  // Saturating event counters and sticky mismatch flag.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.id_exe_flush && !bus.branch_taken && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (bus.branch_taken && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
    // The two write enables are expected to move together; record any skew.
    ctrl_err_d = ctrl_err_q | (bus.pc_write != bus.if_id_write);
  end

  // State registers with synchronous reset that overrides every input.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values and updates together.
    if (rst) begin
      pc_q        <= RESET_PC;
      if_id_q     <= BUBBLE;
      id_exe_q    <= BUBBLE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      ctrl_err_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      if_id_q     <= if_id_d;
      id_exe_q    <= id_exe_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      ctrl_err_q  <= ctrl_err_d;
    end
  end

  // All outputs come straight from registers.
  assign bus.pc           = pc_q;
  assign bus.if_id_instr  = if_id_q.instr;
  assign bus.if_id_pc4    = if_id_q.pc4;
  assign bus.if_id_valid  = if_id_q.valid;
  assign bus.id_exe_instr = id_exe_q.instr;
  assign bus.id_exe_pc4   = id_exe_q.pc4;
  assign bus.id_exe_valid = id_exe_q.valid;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;
  assign bus.ctrl_err     = ctrl_err_q;

endmodule
